mix_columns_iter: RTL and testbench

- Sequential, parametrised MixColumns engine for the AES-128 datapath.
- Takes a 128-bit state through a valid/ready handshake and processes COLS_PER_CYCLE columns per clock.
- Returns the mixed state through a valid/ready handshake.
- Supports forward (encrypt) and, optionally, inverse (decrypt) MixColumns per transaction.
- Sits between ShiftRows and AddRoundKey in the round pipeline; width/area is traded against latency via the parameter.

---
 rtl/aes_pkg.sv | 40 ++++
 rtl/mix_column_unit.sv | 36 +++
 rtl/mix_columns_iter.sv | 107 ++++++++++
 tb/tb_mix_columns_iter.sv | 139 +++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants, MixColumns FSM state type and GF(2^8) multiply helpers.
package aes_pkg;

  localparam int          STATE_W  = 128;
  localparam int          COL_W    = 32;
  localparam int          BYTE_W   = 8;
  localparam logic [7:0]  AES_POLY = 8'h1B;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mc_state_e;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] gmul2(input logic [BYTE_W-1:0] b);
    return xtime(b);
  endfunction

  function automatic logic [BYTE_W-1:0] gmul3(input logic [BYTE_W-1:0] b);
    return xtime(b) ^ b;
  endfunction

  // Inverse coefficients are built from b*8, b*4, b*2 and b.
  function automatic logic [BYTE_W-1:0] gmul9(input logic [BYTE_W-1:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [BYTE_W-1:0] gmul11(input logic [BYTE_W-1:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [BYTE_W-1:0] gmul13(input logic [BYTE_W-1:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [BYTE_W-1:0] gmul14(input logic [BYTE_W-1:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/mix_column_unit.sv
// Combinational MixColumns of one 32-bit column (row 0 = MSB byte).
// Inverse matrix is only built when MIX_COLUMNS_INV_EN is defined.
module mix_column_unit
  import aes_pkg::*;
(
  input  logic [COL_W-1:0] col_i,
  input  logic             inv_i,
  output logic [COL_W-1:0] col_o
);

  logic [BYTE_W-1:0] a0, a1, a2, a3;
  logic [COL_W-1:0]  fwd;

  assign {a0, a1, a2, a3} = col_i;

  assign fwd = {gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3,
                a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3,
                a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3),
                gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3)};

`ifdef MIX_COLUMNS_INV_EN
  logic [COL_W-1:0] inv;

  assign inv = {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};

  assign col_o = inv_i ? inv : fwd;
`else
  logic unused_inv;
  assign unused_inv = inv_i;
  assign col_o      = fwd;
`endif

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative MixColumns engine: COLS_PER_CYCLE columns per clock, valid/ready in and out.
// Define MIX_COLUMNS_INV_EN to honour in_inv; otherwise every state uses the forward matrix.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1,
  parameter int STATE_W        = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_inv,
  input  logic [STATE_W-1:0] in_state,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               busy
);

  localparam int         NGRP = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST = 2'(NGRP - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4) ||
      STATE_W != aes_pkg::STATE_W) begin : g_bad_param
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4 and STATE_W 128");
  end

  mc_state_e                            state_q;
  logic [1:0]                           cnt_q;
  logic                                 inv_q;
  logic [3:0][COL_W-1:0]                work_q;
  logic                                 out_valid_q;
  logic [STATE_W-1:0]                   out_state_q;
  logic [COLS_PER_CYCLE-1:0][1:0]       cidx;
  logic [COLS_PER_CYCLE-1:0][COL_W-1:0] col_in, col_out;
  logic                                 mode_in;

`ifdef MIX_COLUMNS_INV_EN
  assign mode_in = in_inv;
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;
  assign mode_in       = 1'b0;
`endif

  // Column 0 lives in work_q[3] (the MSBs), so column c is work_q[3-c].
  always_comb begin
    cidx   = '0;
    col_in = '0;
    for (int g = 0; g < COLS_PER_CYCLE; g++) begin
      cidx[g]   = 2'(int'(cnt_q) * COLS_PER_CYCLE + g);
      col_in[g] = work_q[2'd3 - cidx[g]];
    end
  end

  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_unit
    mix_column_unit u_mix (
      .col_i (col_in[g]),
      .inv_i (inv_q),
      .col_o (col_out[g])
    );
  end

  // DONE accepts a new state only once the result is on the bus and taken.
  assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_valid_q && out_ready);
  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      inv_q       <= 1'b0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      out_state_q <= '0;
    end else begin
      if (in_valid && in_ready) begin
        work_q <= in_state;
        inv_q  <= mode_in;
        cnt_q  <= '0;
      end
      case (state_q)
        IDLE: if (in_valid) state_q <= CALC;
        CALC: begin
          for (int g = 0; g < COLS_PER_CYCLE; g++)
            work_q[2'd3 - cidx[g]] <= col_out[g];
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == LAST) state_q <= DONE;
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_state_q <= work_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= in_valid ? CALC : IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Directed bench: three engines (1, 2, 4 columns/cycle) share one stimulus stream.
module tb_mix_columns_iter;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_inv, out_ready;
  logic [127:0] in_state;
  logic         ir [3];
  logic         ov [3];
  logic         bz [3];
  logic [127:0] os [3];

  int           total = 0;
  int           bad   = 0;
  int           lat_r [3];
  logic [127:0] res_r [3];
  int           exp_lat [3] = '{5, 3, 2};

  localparam logic [127:0] V_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] V_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] C1_IN  = 128'hdb135345_f20a225c_c6c6c6c6_d4d4d4d5;
  localparam logic [127:0] C1_OUT = 128'h8e4da1bc_9fdc589d_c6c6c6c6_d5d5d7d6;
  localparam logic [127:0] C2_IN  = 128'h01010101_2d26314c_db135345_f20a225c;
  localparam logic [127:0] C2_OUT = 128'h01010101_4d7ebdf8_8e4da1bc_9fdc589d;

  always #5 clk = ~clk;

  mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_inv(in_inv),
    .in_state(in_state), .out_valid(ov[0]), .out_ready(out_ready),
    .out_state(os[0]), .busy(bz[0]));
  mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_inv(in_inv),
    .in_state(in_state), .out_valid(ov[1]), .out_ready(out_ready),
    .out_state(os[1]), .busy(bz[1]));
  mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_inv(in_inv),
    .in_state(in_state), .out_valid(ov[2]), .out_ready(out_ready),
    .out_state(os[2]), .busy(bz[2]));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Starts counting on the negedge right after the acceptance edge.
  task automatic wait_res();
    for (int i = 0; i < 3; i++) begin lat_r[i] = 0; res_r[i] = '0; end
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++)
        if (ov[i] && lat_r[i] == 0) begin lat_r[i] = n; res_r[i] = os[i]; end
    end
  endtask

  // Flips in_inv right after acceptance so only the latched mode may matter.
  task automatic send(input logic [127:0] st, input logic inv);
    @(negedge clk);
    in_valid = 1'b1; in_state = st; in_inv = inv;
    @(negedge clk);
    in_valid = 1'b0; in_inv = ~inv;
    wait_res();
  endtask

  task automatic chk_all(input string tag, input logic [127:0] exp);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_val_u%0d", tag, i), res_r[i], exp);
      chk($sformatf("%s_lat_u%0d", tag, i), 128'(lat_r[i]), 128'(exp_lat[i]));
    end
  endtask

  initial begin
    logic         ok;
    logic [127:0] snap, x, y;
    rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_state = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++)
      chk($sformatf("rst_u%0d", i), {ir[i], ov[i], bz[i], os[i] == '0}, {1'b1, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;

    send(V_IN, 1'b0);  chk_all("fips", V_OUT);
    send(C1_IN, 1'b0); chk_all("cols1", C1_OUT);
    send(C2_IN, 1'b0); chk_all("cols2", C2_OUT);

`ifdef MIX_COLUMNS_INV_EN
    send(V_OUT, 1'b1); chk_all("inv", V_IN);
    for (int k = 0; k < 3; k++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      send(x, 1'b0); y = res_r[0];
      send(y, 1'b1);
      chk($sformatf("rtrip%0d", k), res_r[0], x);
      chk($sformatf("rtrip%0d_u4", k), res_r[2], x);
    end
`else
    send(V_IN, 1'b1); chk_all("inv_off", V_OUT);
`endif

    // Backpressure: result must sit still while out_ready is low.
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; in_state = V_IN; in_inv = 1'b0;
    @(negedge clk); in_valid = 1'b0; in_inv = 1'b1;
    for (int n = 0; n < 12 && !ov[0]; n++) @(negedge clk);
    snap = os[0];
    chk("bp_first", snap, V_OUT);
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!ov[0] || !ov[1] || !ov[2] || os[0] !== snap || os[2] !== V_OUT || ir[0]) ok = 1'b0;
    end
    chk("bp_hold", 128'(ok), 128'd1);
    in_valid = 1'b1; in_state = C1_IN; in_inv = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp_inrdy", {ir[0], ir[1], ir[2]}, 3'b111);
    @(negedge clk); in_valid = 1'b0;
    chk("bp_next_calc", {ov[0], bz[0]}, 2'b01);
    wait_res();
    chk_all("bp_b2b", C1_OUT);

    // Reset on the second CALC cycle throws the state away.
    @(negedge clk); in_valid = 1'b1; in_state = C2_IN;
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++)
      chk($sformatf("midrst_u%0d", i), {ir[i], ov[i], bz[i], os[i] == '0}, {1'b1, 1'b0, 1'b0, 1'b1});
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ov[0] || ov[1] || ov[2] || bz[0]) ok = 1'b0;
    end
    chk("midrst_quiet", 128'(ok), 128'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
